// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller and the pipeline/data-memory side.
// The master side is the controller; the slave side is the datapath that feeds it.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        dmem_valid;
    logic        mem_err;
    logic [31:0] stall_count;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_opcode,
               branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, dmem_valid, mem_err, stall_count
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_opcode,
               branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, dmem_valid, mem_err, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use bubble, branch squash, memory wait/timeout.
// Optional stall-cycle counter is built only when STALL_COUNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter logic [6:0]  LOAD_OPCODE = 7'b0000011,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_ctrl_if.master        hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);
    localparam logic [4:0] EN_ALL    = 5'b11111;

    state_t     state, next_state;
    logic [7:0] wait_cnt, next_cnt;
    logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0] fl;   // {if_id, id_ex, mem_wb}
    logic       dmem_valid;
    logic       mem_err;
    logic       load_use;

    assign load_use = (hz.ex_opcode == LOAD_OPCODE) && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // Outputs are Mealy and forced low while reset is held, independent of inputs.
    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        en         = '0;
        fl         = '0;
        dmem_valid = 1'b0;
        mem_err    = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (hz.mem_req && !hz.mem_ready) begin
                        fl         = 3'b001;
                        dmem_valid = 1'b1;
                        next_state = MEM_WAIT;
                        next_cnt   = 8'd0;
                    end else begin
                        en         = EN_ALL;
                        dmem_valid = hz.mem_req;
                        if (hz.branch_taken) begin
                            fl = 3'b110;
                        end else if (load_use) begin
                            en = 5'b00111;
                            fl = 3'b010;
                        end
                    end
                end
                MEM_WAIT: begin
                    dmem_valid = 1'b1;
                    if (hz.mem_ready) begin
                        en         = EN_ALL;
                        next_state = RUN;
                    end else begin
                        fl = 3'b001;
                        if (wait_cnt == LAST_WAIT) begin
                            next_state = ERROR;
                        end else if (wait_cnt != 8'hFF) begin
                            next_cnt = wait_cnt + 8'd1;
                        end
                    end
                end
                ERROR: begin
                    mem_err = 1'b1;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    assign hz.pc_en        = en[4];
    assign hz.if_id_en     = en[3];
    assign hz.id_ex_en     = en[2];
    assign hz.ex_mem_en    = en[1];
    assign hz.mem_wb_en    = en[0];
    assign hz.if_id_flush  = fl[2];
    assign hz.id_ex_flush  = fl[1];
    assign hz.mem_wb_flush = fl[0];
    assign hz.dmem_valid   = dmem_valid;
    assign hz.mem_err      = mem_err;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt;

    // Counts every edge on which the PC is held, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!en[4]) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign hz.stall_count = stall_cnt;
`else
    assign hz.stall_count = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves three conditions:

- load-use hazards, with a one-cycle bubble
- taken branches, by squashing two younger instructions
- multi-cycle data-memory accesses, through a request/ready handshake with timeout

## Interface

Parameters:
- LOAD_OPCODE, 7'b0000011, opcode identifying a load in EX.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before error; range 1..255.

Ports:
- clk  input  1  pipeline clock; controller state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  input  1 each  the ID instruction reads rs1 / rs2.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_opcode  input  7  opcode of the instruction in EX.
- branch_taken  input  1  EX resolved a taken branch or jump this cycle.
- mem_req  input  1  MEM stage needs a data access this cycle.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  register/PC load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  output  1 each  load a bubble (NOP) instead of data.
- dmem_valid  output  1  request strobe to data memory.
- mem_err  output  1  sticky timeout error.
- stall_count  output  32  stall-cycle counter (see Configuration).

## Operation

State machine (2 bits):
- RUN=0
- MEM_WAIT=1
- ERROR=2
- encoding 3 unused; it returns to RUN.

Priority per cycle: ERROR > memory wait > branch flush > load-use stall > normal.

- **RUN, normal:** all enables 1, all flushes 0; dmem_valid = mem_req.
- **RUN, load-use hazard.** Condition: ex_opcode == LOAD_OPCODE, ex_rd != 0, and either (id_uses_rs1 and id_rs1 == ex_rd) or (id_uses_rs2 and id_rs2 == ex_rd). Response:
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1
  - ex_mem_en = 1, mem_wb_en = 1
  - exactly one bubble; the next cycle re-evaluates with the load now in MEM.
- **RUN, branch_taken:** if_id_flush = 1 and id_ex_flush = 1; all enables 1; the PC loads the target. The load-use condition is ignored that cycle.
- **RUN, mem_req and not mem_ready:**
  - the whole pipe freezes: all enables 0, mem_wb_flush = 1
  - dmem_valid = 1
  - next state MEM_WAIT, wait_cnt cleared to 0
  - branch_taken and the load-use condition are ignored.
- **RUN, mem_req and mem_ready in the same cycle:** no stall.
- **MEM_WAIT:** dmem_valid = 1.
  - mem_ready = 1: all enables 1, flushes 0, next state RUN.
  - mem_ready = 0: freeze as above and wait_cnt increments.
  - wait_cnt == MEM_TIMEOUT-1 with mem_ready = 0: next state ERROR.
- **ERROR:** all enables 0, all flushes 0, dmem_valid = 0, mem_err = 1. The block stays in ERROR until rst_n is asserted.
- wait_cnt is 8 bits and saturates; it never wraps.

## Timing

- Outputs are combinational (Mealy) from state and current inputs, with zero latency.
- Downstream pipeline registers sample on the falling edge, so outputs settle within the clock high phase.
- State, wait_cnt and stall_count update on the rising edge.
- While rst_n = 0, asynchronously and regardless of inputs:
  - state = RUN, wait_cnt = 0, stall_count = 0
  - all enables 0, all flushes 0, dmem_valid = 0, mem_err = 0.
- The first rising edge after rst_n deasserts evaluates from RUN.
- Reset asserted mid-MEM_WAIT or in ERROR returns the block to RUN immediately; the memory request drops the same instant.
- A MEM_WAIT access lasting N cycles costs N-1 extra freeze cycles when ready arrives within the window.
- With MEM_TIMEOUT = T, ERROR is entered on the rising edge ending the T-th MEM_WAIT cycle without ready.

## Configuration

STALL_COUNT_EN:
- **Defined:** stall_count increments by 1 on each rising edge where pc_en = 0 and rst_n = 1, including load-use, MEM_WAIT and ERROR cycles. It wraps from 0xFFFFFFFF to 0.
- **Undefined:** no counter register is built and stall_count is constant 0.

## Test plan

- **Load-use hazard:** ex_opcode = 0000011, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 for one cycle. The same stimulus with ex_rd = 0 -> no stall.
- **Branch over hazard:** branch_taken = 1 together with the load-use condition -> if_id_flush = 1, id_ex_flush = 1, pc_en = 1.
- **Memory wait:** mem_req = 1, with mem_ready low for 3 cycles then high -> 3 frozen cycles with mem_wb_flush = 1 and dmem_valid = 1, then state returns to RUN. With STALL_COUNT_EN defined, stall_count = 3.
- **Timeout:** MEM_TIMEOUT = 4, mem_req = 1, mem_ready held 0 -> ERROR after the 4th MEM_WAIT cycle; mem_err = 1 and all enables 0 persist until reset.
- **Mid-wait reset:** pulse rst_n low during MEM_WAIT -> all outputs 0 immediately; the next cycle with mem_req = 0 shows all enables 1 in RUN.
